// File: rtl/mips32_muldiv.sv
// mips32_muldiv: iterative multiply/divide unit that owns the HI/LO registers.
// It executes MULT, MULTU, DIV and DIVU one bit per cycle, with a fixed latency
// of WIDTH+1 edges from an accepted start to HI/LO being written.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, op, a, b   issue request (sampled only when idle), opcode and operands
//                     (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   flush             squash the operation in flight; HI/LO/div0 stay untouched
//   mthi, mtlo, wdata direct HI/LO writes, honoured only while idle
//   busy              operation in flight
//   done              one-cycle pulse when HI/LO take a new result
//   div0              sticky flag: the last completed divide had a zero divisor
//   hi, lo            architectural HI/LO
module mips32_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation at operand width.
  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1'b1);
  endfunction

  // Two's complement negation at product width.
  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1'b1);
  endfunction

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 isDiv;
  logic                 negRes;   // result (product or quotient) must be negated
  logic                 negRem;   // remainder takes the dividend's negative sign
  logic                 bZero;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds the dividend, replaced bit by bit with the quotient.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvsr;     // |b|: multiplicand or divisor

  logic                 signedOp;
  logic                 aNeg;
  logic                 bNeg;
  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       remShift;
  logic [WIDTH-1:0]     remSub;
  logic                 remFits;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quotFix;
  logic [WIDTH-1:0]     remFix;

  // Operand magnitudes at issue; unsigned ops use the raw values.
  always_comb begin
    signedOp = ~op[0];
    aNeg     = signedOp & a[WIDTH-1];
    bNeg     = signedOp & b[WIDTH-1];
    absA     = aNeg ? negW(a) : a;
    absB     = bNeg ? negW(b) : b;
  end

  // One iteration step for both datapaths, plus the sign fix-up of the result.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : {(WIDTH+1){1'b0}});
    // The shifted partial remainder needs WIDTH+1 bits; after a successful
    // subtract it is below the divisor again, so WIDTH bits suffice for storage.
    remShift = {rem, acc[WIDTH-1]};
    remFits  = (remShift >= {1'b0, dvsr});
    remSub   = remShift[WIDTH-1:0] - dvsr;
    prodFix  = negRes ? neg2W(acc) : acc;
    // A zero divisor leaves |a| in the remainder, so the dividend-sign fix-up
    // below reproduces raw a in HI; only LO needs forcing to all ones.
    quotFix  = bZero ? {WIDTH{1'b1}} : (negRes ? negW(acc[WIDTH-1:0]) : acc[WIDTH-1:0]);
    remFix   = negRem ? negW(rem) : rem;
  end

  // Control FSM, iteration datapath and the architectural HI/LO/div0 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= {CNT_W{1'b0}};
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      bZero  <= 1'b0;
      acc    <= {(2*WIDTH){1'b0}};
      rem    <= {WIDTH{1'b0}};
      dvsr   <= {WIDTH{1'b0}};
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= {WIDTH{1'b0}};
      lo     <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !flush) begin
            state  <= ITER;
            busy   <= 1'b1;
            cnt    <= {CNT_W{1'b0}};
            isDiv  <= op[1];
            negRes <= aNeg ^ bNeg;
            negRem <= aNeg;
            bZero  <= (b == {WIDTH{1'b0}});
            acc    <= {{WIDTH{1'b0}}, absA};
            rem    <= {WIDTH{1'b0}};
            dvsr   <= absB;
          end
        end
        ITER: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (isDiv) begin
              rem              <= remFits ? remSub : remShift[WIDTH-1:0];
              acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], remFits};
            end else begin
              acc <= {mulSum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (isDiv) begin
              hi   <= remFix;
              lo   <= quotFix;
              div0 <= bZero;
            end else begin
              hi <= prodFix[2*WIDTH-1:WIDTH];
              lo <= prodFix[WIDTH-1:0];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_muldiv.sv
// tb_mips32_muldiv: scoreboard bench for mips32_muldiv. The stimulus process
// pushes the expected HI/LO/div0 of each operation that should complete; a
// monitor pops and compares whenever done pulses. Expected values come from
// plain 64-bit arithmetic. A second WIDTH=8 instance covers the narrow build.
module tb_mips32_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, flush, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  logic         start8;
  logic [1:0]   op8;
  logic [7:0]   a8, b8;
  logic         busy8, done8, div08;
  logic [7:0]   hi8, lo8;

  mips32_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div0(div0), .hi(hi), .lo(lo)
  );

  mips32_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(1'b0),
    .mthi(1'b0), .mtlo(1'b0), .wdata(8'h00), .busy(busy8), .done(done8),
    .div0(div08), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           div0;
  } exp_t;

  exp_t         sb[$];
  exp_t         mexp;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hiS, loS;   // expected architectural state, owned by stimulus
  bit           div0S;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics from plain signed/unsigned 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit prev);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] p;
    sx     = longint'($signed(x));
    sy     = longint'($signed(y));
    e.div0 = prev;
    case (o)
      2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'h0, x} * {32'h0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        e.div0 = (y == 32'h0);
        if (y == 32'h0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
        end else if (o == 2'b10) begin
          p = 64'(sx / sy); e.lo = p[31:0];
          p = 64'(sx % sy); e.hi = p[31:0];
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual done=1, expected no completion");
      end else begin
        mexp = sb.pop_front();
        chk("result_hi", hi, mexp.hi);
        chk("result_lo", lo, mexp.lo);
        chk("result_div0", div0, mexp.div0);
      end
    end
  end

  // Drive an issue at the current negedge; push an expectation if it should complete.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e = model(o, x, y, div0S);
      sb.push_back(e);
      hiS = e.hi; loS = e.lo; div0S = e.div0;
    end
  endtask

  task automatic waitDone(input int bound, output int n, output int busyCnt);
    n = -1;
    busyCnt = 0;
    for (int i = 1; i <= bound && n < 0; i++) begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (busy) busyCnt++;
      if (done) n = i;
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual no done in %0d cycles, expected done", bound);
      sb.delete();
    end
  endtask

  task automatic doOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n, bc;
    issue(o, x, y, 1'b1);
    waitDone(W + 10, n, bc);
    if (n > 0) begin
      chk("latency", 64'(n - 1), 64'(W + 1));
      chk("busy_cycles", 64'(bc), 64'(W + 1));
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] eh, input logic [7:0] el);
    int n;
    n = -1;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) n = i;
    end
    chk("w8_latency", 64'(n - 1), 64'd9);
    chk("w8_hi", hi8, eh);
    chk("w8_lo", lo8, el);
    chk("w8_busy", busy8, 1'b0);
    chk("w8_div0", div08, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, prevHi;
    int           n, bc;

    rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = 32'h0; b = 32'h0; wdata = 32'h0;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'h0; b8 = 8'h0;
    hiS = 32'h0; loS = 32'h0; div0S = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_div0", div0, 1'b0);

    // Directed vectors; consecutive doOp calls issue in the done cycle.
    @(negedge clk);
    doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    doOp(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    doOp(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    @(negedge clk);
    doOp(2'b11, 32'h0000_0064, 32'h0);
    doOp(2'b11, 32'h0000_0064, 32'h0000_0007);
    doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    doOp(2'b00, 32'h8000_0000, 32'h8000_0000);
    doOp(2'b10, 32'hFFFF_FFF9, 32'h0);

    // MTLO, then MTHI and MTLO together, in IDLE.
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'hCAFE_BABE; loS = 32'hCAFE_BABE;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFE_BABE);
    chk("mtlo_hi_kept", hi, hiS);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D; hiS = wdata; loS = wdata;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h0BAD_F00D);
    chk("mtboth_lo", lo, 32'h0BAD_F00D);

    // start and mthi while busy are ignored.
    prevHi = hiS;
    issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h7; b = 32'h9; mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi_busy_ignored", hi, prevHi);
    waitDone(W + 10, n, bc);

    // MTHI in the same cycle as an accepted start: visible, then overwritten.
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    issue(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b1);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi_with_start", hi, 32'hA5A5_A5A5);
    waitDone(W + 10, n, bc);

    // Flush at iteration 10: nothing changes and no done follows.
    @(negedge clk);
    issue(2'b11, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_hi", hi, hiS);
    chk("flush_lo", lo, loS);
    chk("flush_div0", div0, div0S);
    repeat (W + 4) @(negedge clk);

    // flush in IDLE suppresses a simultaneous start.
    issue(2'b00, 32'h5, 32'h6, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 1'b0);

    // Set div0 and nonzero HI/LO, then reset in the middle of an operation.
    doOp(2'b11, 32'h0000_0055, 32'h0);
    @(negedge clk);
    issue(2'b10, 32'd12345, 32'd77, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_div0", div0, 1'b0);
    rst = 1'b0; hiS = 32'h0; loS = 32'h0; div0S = 1'b0;
    @(negedge clk);

    // Narrow build.
    run8(2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    @(negedge clk);
    run8(2'b10, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    // Randomised operations, biased toward sign and zero corners.
    @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      doOp(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
